float_unit_arbiter: RTL and testbench

Shares one AXI-stream float unit, such as the 0..255 float clamp or float min/max cores, between NUM_REQ requesters; the R, G and B channels of the shader are the main use case. Requesters are granted in round-robin order. The arbiter records the requester ID of every issued operand in an in-order tag FIFO and routes each result back to its originator. The block adds no latency: issue and return paths are combinational through the arbiter, and only the bookkeeping state is registered.

---
 rtl/float_unit_arbiter_pkg.sv | 42 ++++
 rtl/float_unit_arbiter_tag_fifo.sv | 61 ++++++
 rtl/float_unit_arbiter.sv | 149 ++++++++++++++
 tb/tb_float_unit_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_unit_arbiter_pkg.sv
// Shared types and helpers for the float unit arbiter: grant-state encoding,
// tag width and the round-robin selection function.
package float_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int PICK_W      = 3;
  localparam int NUM_REQ_DEF = 3;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // First set bit of valid, searching upward from ptr and wrapping at num_req.
  // Returns ptr when nothing is valid; callers qualify with the OR of valid.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [NUM_REQ_MAX-1:0] valid,
    input logic [PICK_W-1:0]      ptr,
    input int                     num_req
  );
    logic [PICK_W-1:0] pick;
    logic [PICK_W-1:0] idx_b;
    logic              found;
    int                idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ_MAX; i++) begin
      idx = int'(ptr) + i;
      if (idx >= num_req) begin
        idx = idx - num_req;
      end
      idx_b = PICK_W'(idx);
      if (!found && (i < num_req) && valid[idx_b]) begin
        pick  = idx_b;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/float_unit_arbiter_tag_fifo.sv
// In-order FIFO of requester tags for operands outstanding in the shared unit.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/float_unit_arbiter.sv
// Round-robin sharing of one AXI-stream float unit between NUM_REQ requesters;
// issue and return paths are combinational, only the bookkeeping is registered.
module float_unit_arbiter
  import float_arb_pkg::*;
#(
  parameter int SIZE         = 64,
  parameter int NUM_REQ      = 3,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                            aclk,
  input  logic                            rst,
  input  logic [NUM_REQ*SIZE-1:0]         req_tdata,
  input  logic [NUM_REQ-1:0]              req_tvalid,
  output logic [NUM_REQ-1:0]              req_tready,
  output logic [SIZE-1:0]                 rsp_tdata,
  output logic [NUM_REQ-1:0]              rsp_tvalid,
  input  logic [NUM_REQ-1:0]              rsp_tready,
  output logic [SIZE-1:0]                 unit_s_tdata,
  output logic                            unit_s_tvalid,
  input  logic                            unit_s_tready,
  input  logic [SIZE-1:0]                 unit_m_tdata,
  input  logic                            unit_m_tvalid,
  output logic                            unit_m_tready,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_orphan,
  output arb_state_t                      o_dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]      o_dbg_rr_ptr,
  output logic                            o_dbg_tag_empty
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  // Handshake rule for every stream here: a transfer happens on a rising clock
  // edge where valid and ready are both high; a raised valid and its data stay
  // unchanged until that transfer, and ready may depend combinationally on valid.

  arb_state_t            r_state;
  logic [TAG_W-1:0]      r_rr_ptr;
  logic [TAG_W-1:0]      r_grant;
  logic                  r_err_orphan;

  logic [NUM_REQ_MAX-1:0] w_valid_pad;
  logic [TAG_W-1:0]      w_pick;
  logic [TAG_W-1:0]      w_grant;
  logic [TAG_W-1:0]      w_rr_next;
  logic [TAG_W-1:0]      w_head;
  logic                  w_can_issue;
  logic                  w_issue;
  logic                  w_ret;
  logic                  w_orphan;
  logic                  w_tag_full;
  logic                  w_tag_empty;
  logic [CNT_W-1:0]      w_count;

  always_comb begin
    w_valid_pad                = '0;
    w_valid_pad[NUM_REQ-1:0]   = req_tvalid;
  end

  assign w_pick      = TAG_W'(rr_pick(w_valid_pad, PICK_W'(r_rr_ptr), NUM_REQ));
  assign w_grant     = (r_state == HOLD) ? r_grant : w_pick;
  // Full tag FIFO is exactly inflight == MAX_INFLIGHT; a same-cycle return does not free a slot.
  assign w_can_issue = !w_tag_full;

  assign unit_s_tvalid = !rst && ((r_state == HOLD) || ((|req_tvalid) && w_can_issue));
  assign unit_s_tdata  = req_tdata[int'(w_grant)*SIZE +: SIZE];
  assign w_issue       = unit_s_tvalid && unit_s_tready;

  always_comb begin
    req_tready = '0;
    if (w_issue) begin
      req_tready[w_grant] = 1'b1;
    end
  end

  assign w_rr_next = (w_grant == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

  // Results go to the head tag's owner; with no tag outstanding they are drained and dropped.
  always_comb begin
    rsp_tvalid    = '0;
    unit_m_tready = 1'b0;
    if (!rst) begin
      if (!w_tag_empty) begin
        rsp_tvalid[w_head] = unit_m_tvalid;
        unit_m_tready      = rsp_tready[w_head];
      end else begin
        unit_m_tready      = 1'b1;
      end
    end
  end

  assign rsp_tdata = unit_m_tdata;
  assign w_ret     = !rst && !w_tag_empty && unit_m_tvalid && rsp_tready[w_head];
  assign w_orphan  = !rst && w_tag_empty && unit_m_tvalid;

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_issue) begin
        r_rr_ptr <= w_rr_next;
      end
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          // A stalled offer freezes the grant so a later, closer requester cannot swap the data.
          if (unit_s_tvalid && !unit_s_tready) begin
            r_state <= HOLD;
            r_grant <= w_pick;
          end
        end
        HOLD: begin
          if (w_issue) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk     (aclk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_din   (w_grant),
    .i_pop   (w_ret),
    .o_dout  (w_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_count)
  );

  assign inflight        = w_count;
  assign err_orphan      = r_err_orphan;
  assign o_dbg_state     = r_state;
  assign o_dbg_rr_ptr    = r_rr_ptr;
  assign o_dbg_tag_empty = w_tag_empty;

endmodule

// File: tb/tb_float_unit_arbiter.sv
// Bench for float_unit_arbiter: requester drivers, a pass-through unit stub
// with programmable latency/return budget, and per-requester expected queues.
module tb_float_unit_arbiter;

  localparam int SIZE         = 64;
  localparam int NUM_REQ      = 3;
  localparam int MAX_INFLIGHT = 8;
  localparam int CNT_W        = 4;

  logic                    aclk = 1'b0;
  logic                    rst;
  logic [NUM_REQ*SIZE-1:0] req_tdata;
  logic [NUM_REQ-1:0]      req_tvalid;
  logic [NUM_REQ-1:0]      req_tready;
  logic [SIZE-1:0]         rsp_tdata;
  logic [NUM_REQ-1:0]      rsp_tvalid;
  logic [NUM_REQ-1:0]      rsp_tready;
  logic [SIZE-1:0]         unit_s_tdata;
  logic                    unit_s_tvalid;
  logic                    unit_s_tready;
  logic [SIZE-1:0]         unit_m_tdata;
  logic                    unit_m_tvalid;
  logic                    unit_m_tready;
  logic [CNT_W-1:0]        inflight;
  logic                    err_orphan;
  logic [0:0]              dbg_state;
  logic [1:0]              dbg_rr_ptr;
  logic                    dbg_tag_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [SIZE-1:0] exp_q [NUM_REQ][$];
  int              exp_issue[$];
  int              ret_log[$];
  logic [SIZE-1:0] stub_q[$];
  int              stub_due[$];
  int              stub_lat    = 4;
  int              stub_budget = -1;
  int              src_left [NUM_REQ];
  int              src_seq  [NUM_REQ];
  logic [NUM_REQ-1:0] accepted;
  int              issue_cnt = 0;
  int              mon_id;
  logic [SIZE-1:0] mon_e;

  float_unit_arbiter #(
    .SIZE(SIZE), .NUM_REQ(NUM_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .aclk(aclk), .rst(rst),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .unit_s_tdata(unit_s_tdata), .unit_s_tvalid(unit_s_tvalid), .unit_s_tready(unit_s_tready),
    .unit_m_tdata(unit_m_tdata), .unit_m_tvalid(unit_m_tvalid), .unit_m_tready(unit_m_tready),
    .inflight(inflight), .err_orphan(err_orphan),
    .o_dbg_state(dbg_state), .o_dbg_rr_ptr(dbg_rr_ptr), .o_dbg_tag_empty(dbg_tag_empty)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- requester drivers ----------------
  always @(posedge aclk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accepted[i] || !req_tvalid[i]) begin
        accepted[i] = 1'b0;
        if (src_left[i] > 0) begin
          mon_e = {8'(i), 24'(src_seq[i]), 32'($urandom)};
          src_seq[i]++;
          src_left[i]--;
          req_tdata[i*SIZE +: SIZE] = mon_e;
          req_tvalid[i] = 1'b1;
          exp_q[i].push_back(mon_e);
        end else begin
          req_tvalid[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- unit stub (pass-through) ----------------
  always @(posedge aclk) begin
    #1;
    if (stub_q.size() > 0 && stub_due[0] <= cyc && stub_budget != 0) begin
      unit_m_tvalid = 1'b1;
      unit_m_tdata  = stub_q[0];
    end else begin
      unit_m_tvalid = 1'b0;
      unit_m_tdata  = '0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge aclk) begin
    #2;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_tvalid[i] && req_tready[i]) accepted[i] = 1'b1;
      end
      if (req_tready != '0 && !(unit_s_tvalid && unit_s_tready)) begin
        n_checks++; n_fail++;
        $display("FAIL req_tready_no_issue: req_tready=%b without unit handshake", req_tready);
      end
      if (unit_s_tvalid && unit_s_tready) begin
        issue_cnt++;
        stub_q.push_back(unit_s_tdata);
        stub_due.push_back(cyc + stub_lat);
        mon_id = -1;
        for (int i = 0; i < NUM_REQ; i++) if (req_tready[i]) mon_id = i;
        n_checks++;
        if ($countones(req_tready) != 1) begin
          n_fail++;
          $display("FAIL issue_ready_onehot: req_tready=%b required one-hot", req_tready);
        end
        if (exp_issue.size() > 0) begin
          n_checks++;
          if (mon_id !== exp_issue[0]) begin
            n_fail++;
            $display("FAIL issue_order: granted %0d required %0d", mon_id, exp_issue[0]);
          end
          void'(exp_issue.pop_front());
        end
        if (mon_id >= 0) begin
          n_checks++;
          if (exp_q[mon_id].size() == 0) begin
            n_fail++;
            $display("FAIL issue_data: requester %0d issued with nothing offered", mon_id);
          end else if (unit_s_tdata !== exp_q[mon_id][exp_q[mon_id].size()-1]) begin
            n_fail++;
            $display("FAIL issue_data: got %h required %h", unit_s_tdata,
                     exp_q[mon_id][exp_q[mon_id].size()-1]);
          end
        end
      end
      if (rsp_tvalid != '0) begin
        n_checks++;
        if ($countones(rsp_tvalid) != 1) begin
          n_fail++;
          $display("FAIL rsp_onehot: rsp_tvalid=%b required one-hot", rsp_tvalid);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (rsp_tvalid[i] && rsp_tready[i]) begin
            ret_log.push_back(i);
            n_checks++;
            if (exp_q[i].size() == 0) begin
              n_fail++;
              $display("FAIL rsp_unexpected: requester %0d got %h with none expected", i, rsp_tdata);
            end else begin
              mon_e = exp_q[i].pop_front();
              if (rsp_tdata !== mon_e) begin
                n_fail++;
                $display("FAIL rsp_data[%0d]: got %h required %h", i, rsp_tdata, mon_e);
              end
            end
          end
        end
      end
      if (unit_m_tvalid && unit_m_tready && stub_q.size() > 0) begin
        void'(stub_q.pop_front());
        void'(stub_due.pop_front());
        if (stub_budget > 0) stub_budget--;
      end
    end
  end

  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge aclk);
      if (src_left[0] == 0 && src_left[1] == 0 && src_left[2] == 0 && req_tvalid == '0 &&
          stub_q.size() == 0 && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && inflight == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge aclk);
    req_tdata  = {3{64'h1234_5678_9abc_def0}};
    req_tvalid = 3'b111;
    @(negedge aclk);
    n_checks++; if (unit_s_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_unit_s_tvalid: got %b required 0", unit_s_tvalid); end
    n_checks++; if (req_tready !== 3'b000) begin n_fail++; $display("FAIL rst_req_tready: got %b required 000", req_tready); end
    n_checks++; if (rsp_tvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rsp_tvalid: got %b required 000", rsp_tvalid); end
    n_checks++; if (unit_m_tready !== 1'b0) begin n_fail++; $display("FAIL rst_unit_m_tready: got %b required 0", unit_m_tready); end
    n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d required 0", inflight); end
    n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL rst_err_orphan: got %b required 0", err_orphan); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %b required IDLE", dbg_state); end
    n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rst_rr_ptr: got %0d required 0", dbg_rr_ptr); end
    n_checks++; if (dbg_tag_empty !== 1'b1) begin n_fail++; $display("FAIL rst_tag_empty: got %b required 1", dbg_tag_empty); end
    req_tvalid = 3'b000;
    @(negedge aclk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    bit ok;
    int base;
    base = issue_cnt;
    exp_issue = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < NUM_REQ; i++) src_left[i] = 2;
    wait_drain(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_drain: timeout, inflight=%0d", inflight); end
    n_checks++; if (issue_cnt - base != 6) begin n_fail++; $display("FAIL rr_issue_count: got %0d required 6", issue_cnt - base); end
    n_checks++; if (exp_issue.size() != 0) begin n_fail++; $display("FAIL rr_issue_left: %0d expected issues not seen", exp_issue.size()); end
  endtask

  task automatic test_hold_stability();
    bit ok;
    bit seen;
    logic [SIZE-1:0] held;
    unit_s_tready = 1'b0;
    src_left[0] = 1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge aclk);
      if (unit_s_tvalid) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL hold_offer: unit_s_tvalid got 0 required 1"); end
    held = exp_q[0][exp_q[0].size()-1];
    src_left[2] = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      n_checks++; if (unit_s_tvalid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b required 1", unit_s_tvalid); end
      n_checks++; if (unit_s_tdata !== held) begin n_fail++; $display("FAIL hold_data: got %h required %h", unit_s_tdata, held); end
      n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL hold_state: got %b required HOLD", dbg_state); end
    end
    exp_issue = '{0, 2};
    unit_s_tready = 1'b1;
    wait_drain(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_drain: timeout, inflight=%0d", inflight); end
    n_checks++; if (exp_issue.size() != 0) begin n_fail++; $display("FAIL hold_issue_left: %0d expected issues not seen", exp_issue.size()); end
  endtask

  task automatic test_inflight_limit();
    bit ok;
    int base;
    base = issue_cnt;
    stub_budget = 0;
    src_left[1] = 12;
    repeat (25) @(negedge aclk);
    n_checks++; if (issue_cnt - base != 8) begin n_fail++; $display("FAIL limit_issues: got %0d required 8", issue_cnt - base); end
    n_checks++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL limit_inflight: got %0d required 8", inflight); end
    n_checks++; if (unit_s_tvalid !== 1'b0) begin n_fail++; $display("FAIL limit_valid: got %b required 0", unit_s_tvalid); end
    stub_budget = 1;
    repeat (20) @(negedge aclk);
    n_checks++; if (issue_cnt - base != 9) begin n_fail++; $display("FAIL limit_one_more: got %0d required 9", issue_cnt - base); end
    n_checks++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL limit_inflight2: got %0d required 8", inflight); end
    stub_budget = -1;
    wait_drain(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL limit_drain: timeout, inflight=%0d", inflight); end
  endtask

  task automatic test_head_of_line();
    bit ok;
    stub_budget = 0;
    exp_issue = '{1, 2, 0};
    ret_log.delete();
    src_left[1] = 1;
    repeat (5) @(negedge aclk);
    src_left[0] = 1;
    src_left[2] = 1;
    repeat (8) @(negedge aclk);
    n_checks++; if (inflight !== 4'd3) begin n_fail++; $display("FAIL hol_inflight: got %0d required 3", inflight); end
    rsp_tready[1] = 1'b0;
    stub_budget = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      n_checks++; if (unit_m_tready !== 1'b0) begin n_fail++; $display("FAIL hol_m_tready: got %b required 0", unit_m_tready); end
      n_checks++; if (rsp_tvalid !== 3'b010) begin n_fail++; $display("FAIL hol_rsp_tvalid: got %b required 010", rsp_tvalid); end
    end
    rsp_tready[1] = 1'b1;
    wait_drain(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hol_drain: timeout, inflight=%0d", inflight); end
    n_checks++;
    if (ret_log.size() != 3 || ret_log[0] != 1 || ret_log[1] != 2 || ret_log[2] != 0) begin
      n_fail++;
      $display("FAIL hol_ret_order: got %0d returns (%p) required 1,2,0", ret_log.size(), ret_log);
    end
  endtask

  task automatic test_orphan();
    bit seen;
    n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_pre: got %b required 0", err_orphan); end
    stub_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
    stub_due.push_back(0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge aclk);
      if (unit_m_tvalid) begin
        n_checks++; if (unit_m_tready !== 1'b1) begin n_fail++; $display("FAIL orphan_m_tready: got %b required 1", unit_m_tready); end
        n_checks++; if (rsp_tvalid !== 3'b000) begin n_fail++; $display("FAIL orphan_rsp: got %b required 000", rsp_tvalid); end
      end
      if (err_orphan) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL orphan_set: err_orphan got 0 required 1"); end
    n_checks++; if (stub_q.size() != 0) begin n_fail++; $display("FAIL orphan_drop: %0d results left in unit", stub_q.size()); end
    repeat (5) @(negedge aclk);
    n_checks++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b required 1", err_orphan); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    stub_budget = 0;
    src_left[0] = 5;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge aclk);
      if (inflight == 4'd5) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_fill: inflight got %0d required 5", inflight); end
    unit_s_tready = 1'b0;
    src_left[1] = 1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge aclk);
      if (dbg_state == 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_hold: state got %b required HOLD", dbg_state); end
    rst = 1'b1;
    @(negedge aclk);
    n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL mid_inflight: got %0d required 0", inflight); end
    n_checks++; if (dbg_tag_empty !== 1'b1) begin n_fail++; $display("FAIL mid_tag_empty: got %b required 1", dbg_tag_empty); end
    n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL mid_rr_ptr: got %0d required 0", dbg_rr_ptr); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL mid_state: got %b required IDLE", dbg_state); end
    n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL mid_err_orphan: got %b required 0", err_orphan); end
    n_checks++;
    if (unit_s_tvalid !== 1'b0 || req_tready !== 3'b000 || rsp_tvalid !== 3'b000 || unit_m_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_outputs: s_tvalid=%b req_tready=%b rsp_tvalid=%b m_tready=%b required all 0",
               unit_s_tvalid, req_tready, rsp_tvalid, unit_m_tready);
    end
    req_tvalid = 3'b000;
    accepted   = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_left[i] = 0;
      exp_q[i].delete();
    end
    stub_q.delete();
    stub_due.delete();
    exp_issue.delete();
    @(negedge aclk);
    rst = 1'b0;
    unit_s_tready = 1'b1;
    stub_budget = -1;
    exp_issue = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < NUM_REQ; i++) src_left[i] = 2;
    wait_drain(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_resume_drain: timeout, inflight=%0d", inflight); end
    n_checks++; if (exp_issue.size() != 0) begin n_fail++; $display("FAIL mid_resume_order: %0d expected issues not seen", exp_issue.size()); end
    n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL mid_resume_orphan: got %b required 0", err_orphan); end
  endtask

  initial begin
    rst           = 1'b1;
    req_tdata     = '0;
    req_tvalid    = '0;
    rsp_tready    = 3'b111;
    unit_s_tready = 1'b1;
    unit_m_tvalid = 1'b0;
    unit_m_tdata  = '0;
    accepted      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_left[i] = 0;
      src_seq[i]  = 0;
    end
    repeat (2) @(negedge aclk);
    test_reset();
    test_round_robin();
    test_hold_stability();
    test_inflight_limit();
    test_head_of_line();
    test_orphan();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
